// File: rtl/smaesh_pkg.sv
// Shared encodings for the SMAESH input framer: word types, FSM states and frame geometry.
package smaesh_pkg;

  typedef enum logic [1:0] {
    TYPE_SEED = 2'd0,
    TYPE_KEY  = 2'd1,
    TYPE_DATA = 2'd2,
    TYPE_RSVD = 2'd3
  } word_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DROP    = 2'd2
  } framer_state_e;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned SEED_WORDS = 3;
  localparam int unsigned SEED_W     = 80;
  localparam int unsigned SHARE_W    = 128;

  function automatic int unsigned shared_words(input int unsigned shares);
    return 4 * shares;
  endfunction

  // Number of words that make up a complete frame of the given type.
  function automatic int unsigned frame_len(input word_type_e t, input int unsigned shares);
    case (t)
      TYPE_SEED:            return SEED_WORDS;
      TYPE_KEY, TYPE_DATA:  return shared_words(shares);
      default:              return 0;
    endcase
  endfunction

endpackage

// File: rtl/smaesh_framer_slot.sv
// One frame buffer: words written in place by index, plus the valid/ready output handshake.
module smaesh_framer_slot
  import smaesh_pkg::*;
#(
  parameter int unsigned WORDS = 3,
  parameter int unsigned KEEP  = 96,
  parameter int unsigned IW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              done,
  input  logic              ready,
  output logic [KEEP-1:0]   frame,
  output logic              valid
);

  // Bits beyond KEEP are never stored, so a partially kept top word is simply narrower.
  for (genvar k = 0; k < WORDS; k++) begin : g_word
    localparam int unsigned LO = WORD_W * k;
    localparam int unsigned WB = (KEEP - LO >= WORD_W) ? WORD_W : KEEP - LO;

    logic [WB-1:0] word_q;

    always_ff @(posedge clk) begin
      if (wr_en && (wr_idx == IW'(k))) begin
        word_q <= wr_word[WB-1:0];
      end
    end

    assign frame[LO +: WB] = word_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (done) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/smaesh_input_framer.sv
// Splits a typed 32-bit word stream into seed, shared-key and shared-data frames.
// Define SMAESH_FRAMER_ERR_EN to enable protocol checking, the sticky err flag and the DROP state.
module smaesh_input_framer
  import smaesh_pkg::*;
#(
  parameter int unsigned d = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_W-1:0]    s_word,
  input  logic [1:0]           s_type,
  input  logic                 s_last,
  output logic [SEED_W-1:0]    out_seed,
  output logic                 out_seed_valid,
  input  logic                 out_seed_ready,
  output logic [SHARE_W*d-1:0] out_key,
  output logic                 out_key_valid,
  input  logic                 out_key_ready,
  output logic [SHARE_W*d-1:0] out_data,
  output logic                 out_data_valid,
  input  logic                 out_data_ready,
  output logic                 err
);

  localparam int unsigned NW = shared_words(d);
  localparam int unsigned CW = $clog2(NW + 1);

  framer_state_e state_q, state_d;
  word_type_e    type_q, type_d, tgt_c;
  logic [CW-1:0] cnt_q, cnt_d, len_c;
  logic          tgt_busy_c, fire_c, final_c, wr_en_c, done_c;

  // Target buffer: the frame in progress, or the type of the word on the bus when idle.
  assign tgt_c = (state_q == ST_COLLECT) ? type_q : word_type_e'(s_type);

  always_comb begin
    tgt_busy_c = 1'b0;
    case (tgt_c)
      TYPE_SEED: tgt_busy_c = out_seed_valid;
      TYPE_KEY:  tgt_busy_c = out_key_valid;
      TYPE_DATA: tgt_busy_c = out_data_valid;
      default:   tgt_busy_c = 1'b0;
    endcase
  end

  assign s_ready = !rst && ((state_q == ST_DROP) || !tgt_busy_c);
  assign fire_c  = s_valid && s_ready;
  assign len_c   = CW'(frame_len(tgt_c, d));
  // Counter is zero in IDLE, so this also flags a single-word frame on its first word.
  assign final_c = (cnt_q + CW'(1)) == len_c;

`ifdef SMAESH_FRAMER_ERR_EN
  logic err_q, err_d;
  assign err = err_q;
`else
  logic unused_last;
  assign unused_last = s_last;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    wr_en_c = 1'b0;
    done_c  = 1'b0;
`ifdef SMAESH_FRAMER_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (fire_c) begin
`ifdef SMAESH_FRAMER_ERR_EN
          if ((tgt_c == TYPE_RSVD) || (word_type_e'(s_type) != tgt_c) || (s_last != final_c)) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = s_last ? ST_IDLE : ST_DROP;
          end else
`endif
          if (tgt_c != TYPE_RSVD) begin
            wr_en_c = 1'b1;
            type_d  = tgt_c;
            if (final_c) begin
              done_c  = 1'b1;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d   = cnt_q + CW'(1);
              state_d = ST_COLLECT;
            end
          end
        end
      end
`ifdef SMAESH_FRAMER_ERR_EN
      ST_DROP: begin
        if (fire_c && s_last) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      type_q  <= TYPE_SEED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SMAESH_FRAMER_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  smaesh_framer_slot #(
    .WORDS (SEED_WORDS),
    .KEEP  (SEED_W),
    .IW    (CW)
  ) u_seed (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_c && (tgt_c == TYPE_SEED)),
    .wr_idx  (cnt_q),
    .wr_word (s_word),
    .done    (done_c && (tgt_c == TYPE_SEED)),
    .ready   (out_seed_ready),
    .frame   (out_seed),
    .valid   (out_seed_valid)
  );

  smaesh_framer_slot #(
    .WORDS (NW),
    .KEEP  (SHARE_W * d),
    .IW    (CW)
  ) u_key (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_c && (tgt_c == TYPE_KEY)),
    .wr_idx  (cnt_q),
    .wr_word (s_word),
    .done    (done_c && (tgt_c == TYPE_KEY)),
    .ready   (out_key_ready),
    .frame   (out_key),
    .valid   (out_key_valid)
  );

  smaesh_framer_slot #(
    .WORDS (NW),
    .KEEP  (SHARE_W * d),
    .IW    (CW)
  ) u_data (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_c && (tgt_c == TYPE_DATA)),
    .wr_idx  (cnt_q),
    .wr_word (s_word),
    .done    (done_c && (tgt_c == TYPE_DATA)),
    .ready   (out_data_ready),
    .frame   (out_data),
    .valid   (out_data_valid)
  );

endmodule

// File: tb/tb_smaesh_input_framer.sv
// Self-checking bench for smaesh_input_framer (d=2): vector table, directed corner cases, random scoreboard.
`timescale 1ns/1ps
module tb_smaesh_input_framer;

  localparam int unsigned D  = 2;
  localparam int unsigned NW = 4 * D;
  localparam int unsigned FW = 128 * D;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [31:0]   s_word;
  logic [1:0]    s_type;
  logic [79:0]   out_seed;
  logic          out_seed_valid, out_seed_ready;
  logic [FW-1:0] out_key, out_data;
  logic          out_key_valid, out_key_ready;
  logic          out_data_valid, out_data_ready;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  smaesh_input_framer #(.d(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_word         (s_word),
    .s_type         (s_type),
    .s_last         (s_last),
    .out_seed       (out_seed),
    .out_seed_valid (out_seed_valid),
    .out_seed_ready (out_seed_ready),
    .out_key        (out_key),
    .out_key_valid  (out_key_valid),
    .out_key_ready  (out_key_ready),
    .out_data       (out_data),
    .out_data_valid (out_data_valid),
    .out_data_ready (out_data_ready),
    .err            (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int flen(input int t);
    return (t == 0) ? 3 : NW;
  endfunction

  function automatic logic [FW-1:0] frame_of(input int t);
    case (t)
      0:       return FW'(out_seed);
      1:       return out_key;
      default: return out_data;
    endcase
  endfunction

  function automatic logic valid_of(input int t);
    case (t)
      0:       return out_seed_valid;
      1:       return out_key_valid;
      default: return out_data_valid;
    endcase
  endfunction

  function automatic logic ready_of(input int t);
    case (t)
      0:       return out_seed_ready;
      1:       return out_key_ready;
      default: return out_data_ready;
    endcase
  endfunction

  function automatic logic [FW-1:0] exp_frame(input logic [31:0] base, input logic [31:0] step, input int n);
    logic [FW-1:0] f = '0;
    for (int k = 0; k < n; k++) f[32*k +: 32] = base + 32'(k) * step;
    if (n == 3) f = FW'(f[79:0]);
    return f;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until the framer accepts it; returns just after the transfer edge.
  task automatic send_word(input logic [31:0] w, input logic [1:0] t, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_word  = w;
    s_type  = t;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_word_timeout: s_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int t, input logic [31:0] base, input logic [31:0] step);
    for (int k = 0; k < flen(t); k++) send_word(base + 32'(k) * step, 2'(t), k == flen(t) - 1);
  endtask

  // Scoreboard: frames assembled from accepted words by plain list arithmetic.
  logic          sb_on = 1'b0;
  logic          rr_on = 1'b0;
  logic [FW-1:0] expq [3][$];
  int            m_len = 0;
  int            m_type = 0;
  logic [31:0]   m_words [NW];

  function automatic void model_word(input logic [31:0] w, input logic [1:0] t);
    if (m_len == 0) begin
      if (t == 2'd3) return;
      m_type = int'(t);
    end
    m_words[m_len] = w;
    m_len++;
    if (m_len == flen(m_type)) begin
      logic [FW-1:0] f;
      f = '0;
      for (int k = 0; k < m_len; k++) f[32*k +: 32] = m_words[k];
      if (m_type == 0) f = FW'(f[79:0]);
      expq[m_type].push_back(f);
      m_len = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (sb_on && !rst) begin
      for (int t = 0; t < 3; t++) begin
        if (valid_of(t) && ready_of(t)) begin
          if (expq[t].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_frame type %0d: got %0h expected none", t, frame_of(t));
          end else begin
            check($sformatf("sb_frame_type%0d", t), frame_of(t), expq[t].pop_front());
          end
        end
      end
      if (s_valid && s_ready) model_word(s_word, s_type);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_on) begin
        out_seed_ready = 1'($urandom_range(0, 1));
        out_key_ready  = 1'($urandom_range(0, 1));
        out_data_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  int  dv_cnt = 0;
  logic dv_on = 1'b0;
  always @(negedge clk) if (dv_on && out_data_valid) dv_cnt++;

  typedef struct {
    int            typ;
    logic [31:0]   base;
    logic [31:0]   step;
    logic [FW-1:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{typ: 0, base: 32'h11111111, step: 32'h11111111, exp: FW'(80'h3333_22222222_11111111)};
    vecs[1] = '{typ: 1, base: 32'h00000000, step: 32'h00000001,
                exp: 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000};
    vecs[2] = '{typ: 2, base: 32'hA0000000, step: 32'h00000010,
                exp: 256'hA0000070_A0000060_A0000050_A0000040_A0000030_A0000020_A0000010_A0000000};
    vecs[3] = '{typ: 0, base: 32'hFFFFFFFF, step: 32'hFFFFFFFF, exp: FW'(80'hFFFD_FFFFFFFE_FFFFFFFF)};
    vecs[4] = '{typ: 1, base: 32'hDEAD0000, step: 32'h00010001,
                exp: 256'hDEB40007_DEB30006_DEB20005_DEB10004_DEB00003_DEAF0002_DEAE0001_DEAD0000};

    rst = 1'b1;
    s_valid = 1'b0; s_word = '0; s_type = '0; s_last = 1'b0;
    out_seed_ready = 1'b1; out_key_ready = 1'b1; out_data_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_s_ready", s_ready, 0);
    check("reset_valids", {out_seed_valid, out_key_valid, out_data_valid}, 0);
    check("reset_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1);
    check("idle_s_ready", s_ready, 1);

    // Vector table: one frame per entry, ready held high.
    foreach (vecs[i]) begin
      for (int k = 0; k < flen(vecs[i].typ); k++) begin
        if (k == flen(vecs[i].typ) - 1) check($sformatf("vec%0d_pre_valid", i), valid_of(vecs[i].typ), 0);
        send_word(vecs[i].base + 32'(k) * vecs[i].step, 2'(vecs[i].typ), k == flen(vecs[i].typ) - 1);
      end
      check($sformatf("vec%0d_valid", i), valid_of(vecs[i].typ), 1);
      check($sformatf("vec%0d_value", i), frame_of(vecs[i].typ), vecs[i].exp);
      cyc(1);
      check($sformatf("vec%0d_valid_fall", i), valid_of(vecs[i].typ), 0);
    end

    // Seed held under backpressure, then the one-cycle bubble for the next seed frame.
    out_seed_ready = 1'b0;
    send_word(32'h11111111, 2'd0, 1'b0);
    send_word(32'h22222222, 2'd0, 1'b0);
    send_word(32'hFFFF3333, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("seed_hold_valid%0d", i), out_seed_valid, 1);
      check($sformatf("seed_hold_value%0d", i), FW'(out_seed), FW'(80'h3333_22222222_11111111));
      cyc(1);
    end
    s_valid = 1'b1; s_word = 32'hAAAA0001; s_type = 2'd0; s_last = 1'b0;
    check("seed2_blocked", s_ready, 0);
    out_seed_ready = 1'b1;
    @(negedge clk);
    check("seed2_blocked_in_transfer", s_ready, 0);
    @(posedge clk); #1;
    out_seed_ready = 1'b0;
    check("seed_valid_after_transfer", out_seed_valid, 0);
    check("seed2_ready_after_bubble", s_ready, 1);
    send_word(32'hAAAA0001, 2'd0, 1'b0);
    send_word(32'hAAAA0002, 2'd0, 1'b0);
    send_word(32'hAAAA0003, 2'd0, 1'b1);
    check("seed2_valid", out_seed_valid, 1);
    check("seed2_value", FW'(out_seed), FW'(80'h0003_AAAA0002_AAAA0001));
    out_seed_ready = 1'b1;
    cyc(1);

    // Pending key frame does not block data collection.
    out_key_ready = 1'b0; out_data_ready = 1'b0;
    send_frame(1, 32'h00000100, 32'h1);
    send_frame(2, 32'h00000200, 32'h1);
    check("indep_key_valid", out_key_valid, 1);
    check("indep_data_valid", out_data_valid, 1);
    check("indep_key_value", out_key, exp_frame(32'h100, 32'h1, 8));
    check("indep_data_value", out_data, exp_frame(32'h200, 32'h1, 8));
    out_key_ready = 1'b1; out_data_ready = 1'b1;
    cyc(1);
    check("indep_valids_fall", {out_key_valid, out_data_valid}, 0);

`ifdef SMAESH_FRAMER_ERR_EN
    // Type switch inside a key frame: dropped through s_last, err sticky.
    for (int k = 0; k < 8; k++) send_word(32'h700 + 32'(k), (k < 3) ? 2'd1 : 2'd2, k == 7);
    cyc(2);
    check("err_set", err, 1);
    check("err_no_valid", {out_seed_valid, out_key_valid, out_data_valid}, 0);
    send_frame(2, 32'h00000300, 32'h1);
    check("err_clean_data_valid", out_data_valid, 1);
    check("err_clean_data_value", out_data, exp_frame(32'h300, 32'h1, 8));
    check("err_sticky", err, 1);
    cyc(1);
`else
    // Reserved words are swallowed; s_last and mid-frame type are ignored.
    send_word(32'hBADBAD00, 2'd3, 1'b1);
    cyc(2);
    check("rsvd_no_valid", {out_seed_valid, out_key_valid, out_data_valid}, 0);
    for (int k = 0; k < 8; k++) send_word(32'h800 + 32'(k), (k >= 2 && k <= 5) ? 2'd2 : 2'd1, k == 2);
    check("lax_key_valid", out_key_valid, 1);
    check("lax_key_value", out_key, exp_frame(32'h800, 32'h1, 8));
    check("lax_no_data", out_data_valid, 0);
    check("lax_err_zero", err, 0);
    cyc(1);
`endif

    // Reset mid-frame discards the partial frame.
    for (int k = 0; k < 5; k++) send_word(32'h500 + 32'(k), 2'd2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dv_cnt = 0; dv_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) check("midrst_no_early_valid", out_data_valid, 0);
      send_word(32'h600 + 32'(k), 2'd2, k == 7);
    end
    check("midrst_value", out_data, exp_frame(32'h600, 32'h1, 8));
    cyc(4);
    dv_on = 1'b0;
    check("midrst_valid_count", 32'(dv_cnt), 1);

    // Random frames against the scoreboard with random output backpressure.
    cyc(2);
    sb_on = 1'b1;
    rr_on = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int t;
      t = $urandom_range(0, 2);
`ifndef SMAESH_FRAMER_ERR_EN
      if ($urandom_range(0, 3) == 0) send_word($urandom, 2'd3, 1'($urandom_range(0, 1)));
`endif
      for (int k = 0; k < flen(t); k++) begin
        logic [1:0] tt;
        logic       l;
        tt = 2'(t);
        l  = (k == flen(t) - 1);
`ifndef SMAESH_FRAMER_ERR_EN
        if (k > 0 && $urandom_range(0, 4) == 0) tt = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) l = ~l;
`endif
        send_word($urandom, tt, l);
        if ($urandom_range(0, 3) == 0) cyc(1);
      end
    end
    rr_on = 1'b0;
    cyc(2);
    out_seed_ready = 1'b1; out_key_ready = 1'b1; out_data_ready = 1'b1;
    cyc(5);
    check("sb_drain_seed", 32'(expq[0].size()), 0);
    check("sb_drain_key", 32'(expq[1].size()), 0);
    check("sb_drain_data", 32'(expq[2].size()), 0);
    check("sb_no_partial", 32'(m_len), 0);
    sb_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
